contador_timer_bcd: RTL and testbench

CONTADOR_TIMER_BCD -- requirements
Module: contador_timer_bcd

---
 rtl/contador_timer_bcd_pkg.sv | 34 +++
 rtl/contador_timer_bcd_bcd_2dig.sv | 40 ++++
 rtl/contador_timer_bcd.sv | 137 +++++++++++++
 tb/tb_contador_timer_bcd.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_timer_bcd_pkg.sv
// ============================================================
// Module : contador_timer_bcd_pkg
// Desc   : Shared state encoding, default limits and BCD helpers
// Rev    : 1.0
// ============================================================
`default_nettype none

package contador_timer_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] C_HORA_MAX_DEF   = 8'h23;
  localparam logic [7:0] C_MINSEG_MAX_DEF = 8'h59;
  localparam logic [7:0] C_BCD_ZERO       = 8'h00;

  // Increment a valid 2-digit BCD value; the caller handles the wrap at the terminal value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

endpackage

`default_nettype wire

// File: rtl/contador_timer_bcd_bcd_2dig.sv
// ============================================================
// Module : contador_bcd_2dig
// Desc   : Two-digit BCD register with clear, load, increment and wrap carry
// Rev    : 1.0
// ============================================================
`default_nettype none

module contador_bcd_2dig
  import contador_timer_bcd_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic       i_inc,
  input  logic [7:0] i_load_val,
  input  logic [7:0] i_max_val,
  output logic [7:0] o_value,
  output logic       o_carry
);

  logic [7:0] r_value;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_value <= C_BCD_ZERO;
    else if (i_clr)
      r_value <= C_BCD_ZERO;
    else if (i_load)
      r_value <= i_load_val;
    else if (i_inc)
      r_value <= (r_value == i_max_val) ? C_BCD_ZERO : bcd_inc(r_value);
  end

  assign o_carry = i_inc && (r_value == i_max_val);
  assign o_value = r_value;

endmodule

`default_nettype wire

// File: rtl/contador_timer_bcd.sv
// ============================================================
// Module : contador_timer_bcd
// Desc   : HH:MM:SS BCD elapsed-time counter with run/pause/load control
// Rev    : 1.0
// ============================================================
`default_nettype none

module contador_timer_bcd
  import contador_timer_bcd_pkg::*;
#(
  parameter logic [7:0] HORA_MAX   = C_HORA_MAX_DEF,
  parameter logic [7:0] MINSEG_MAX = C_MINSEG_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] hora_load,
  input  logic [7:0] minuto_load,
  input  logic [7:0] segundo_load,
  output logic [7:0] hora_out,
  output logic [7:0] minuto_out,
  output logic [7:0] segundo_out,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  state_t r_state;
  state_t w_next_state;
  logic   r_load_err;

  logic w_clr;
  logic w_load;
  logic w_load_err;
  logic w_tick_en;
  logic w_seg_carry;
  logic w_min_carry;
  logic w_unused_hora_carry;
  logic w_load_ok;
  logic w_hits_term;
  logic w_can_load;

  assign w_can_load = (r_state == ST_IDLE) || (r_state == ST_PAUSE);

  assign w_load_ok = bcd_valid(hora_load, HORA_MAX)
                  && bcd_valid(minuto_load, MINSEG_MAX)
                  && bcd_valid(segundo_load, MINSEG_MAX)
                  && ({hora_load, minuto_load, segundo_load}
                      != {HORA_MAX, MINSEG_MAX, MINSEG_MAX});

  // The next tick lands exactly on the terminal count.
  assign w_hits_term = (hora_out == HORA_MAX) && (minuto_out == MINSEG_MAX)
                    && (bcd_inc(segundo_out) == MINSEG_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_load_err <= w_load_err;
    end
  end

  // A command ignored in the current state falls through to the next lower priority one.
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_load       = 1'b0;
    w_load_err   = 1'b0;
    w_tick_en    = 1'b0;
    if (clear) begin
      w_next_state = ST_IDLE;
      w_clr        = 1'b1;
    end else if (load && w_can_load) begin
      if (w_load_ok)
        w_load = 1'b1;
      else
        w_load_err = 1'b1;
    end else if (stop && (r_state == ST_RUN)) begin
      w_next_state = ST_PAUSE;
    end else if (start && w_can_load) begin
      w_next_state = ST_RUN;
    end else if (tick_1hz && (r_state == ST_RUN)) begin
      w_tick_en = 1'b1;
      if (w_hits_term)
        w_next_state = ST_DONE;
    end
  end

  contador_bcd_2dig u_segundo (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_inc      (w_tick_en),
    .i_load_val (segundo_load),
    .i_max_val  (MINSEG_MAX),
    .o_value    (segundo_out),
    .o_carry    (w_seg_carry)
  );

  contador_bcd_2dig u_minuto (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_inc      (w_seg_carry),
    .i_load_val (minuto_load),
    .i_max_val  (MINSEG_MAX),
    .o_value    (minuto_out),
    .o_carry    (w_min_carry)
  );

  contador_bcd_2dig u_hora (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_inc      (w_min_carry),
    .i_load_val (hora_load),
    .i_max_val  (HORA_MAX),
    .o_value    (hora_out),
    .o_carry    (w_unused_hora_carry)
  );

  assign running  = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);
  assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_contador_timer_bcd.sv
// ============================================================
// Module : tb_contador_timer_bcd
// Desc   : Scoreboard bench against a seconds-based reference model
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_contador_timer_bcd;

  localparam int HMAX  = 23;
  localparam int MSMAX = 59;
  localparam int TERM  = HMAX * 3600 + MSMAX * 60 + MSMAX;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       run;
    logic       dn;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic [7:0] hora_load = 8'h00, minuto_load = 8'h00, segundo_load = 8'h00;
  logic [7:0] hora_out, minuto_out, segundo_out;
  logic       running, done, load_err;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  int m_t    = 0;
  int m_mode = M_IDLE;

  contador_timer_bcd #(.HORA_MAX(8'h23), .MINSEG_MAX(8'h59)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .load         (load),
    .hora_load    (hora_load),
    .minuto_load  (minuto_load),
    .segundo_load (segundo_load),
    .hora_out     (hora_out),
    .minuto_out   (minuto_out),
    .segundo_out  (segundo_out),
    .running      (running),
    .done         (done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic bit field_ok(input logic [7:0] v, input int max);
    int n;
    n = int'(v[7:4]) * 10 + int'(v[3:0]);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (n <= max);
  endfunction

  function automatic int dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endfunction

  // Reference model: elapsed time kept as plain seconds.
  function automatic exp_t model_step(input logic c, l, sp, st, tk,
                                      input logic [7:0] h, m, s);
    exp_t e;
    bit err = 0;
    bit can_load = (m_mode == M_IDLE) || (m_mode == M_PAUSE);
    if (c) begin
      m_mode = M_IDLE;
      m_t = 0;
    end else if (l && can_load) begin
      if (field_ok(h, HMAX) && field_ok(m, MSMAX) && field_ok(s, MSMAX) &&
          (dec(h) * 3600 + dec(m) * 60 + dec(s) != TERM))
        m_t = dec(h) * 3600 + dec(m) * 60 + dec(s);
      else
        err = 1;
    end else if (sp && m_mode == M_RUN) begin
      m_mode = M_PAUSE;
    end else if (st && can_load) begin
      m_mode = M_RUN;
    end else if (tk && m_mode == M_RUN) begin
      m_t++;
      if (m_t == TERM) m_mode = M_DONE;
    end
    e.h   = to_bcd(m_t / 3600);
    e.m   = to_bcd((m_t / 60) % 60);
    e.s   = to_bcd(m_t % 60);
    e.run = (m_mode == M_RUN);
    e.dn  = (m_mode == M_DONE);
    e.err = err;
    return e;
  endfunction

  task automatic cyc(input logic c, l, sp, st, tk, input logic [7:0] h, m, s);
    @(negedge clk);
    clear = c; load = l; stop = sp; start = st; tick_1hz = tk;
    hora_load = h; minuto_load = m; segundo_load = s;
    exp_q.push_back(model_step(c, l, sp, st, tk, h, m, s));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic tick();
    cyc(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
  endtask

  // Monitor: every post-edge sample consumes one expected response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hora",     hora_out,          e.h);
        chk("minuto",   minuto_out,        e.m);
        chk("segundo",  segundo_out,       e.s);
        chk("running",  {7'd0, running},   {7'd0, e.run});
        chk("done",     {7'd0, done},      {7'd0, e.dn});
        chk("load_err", {7'd0, load_err},  {7'd0, e.err});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic c, l, sp, st, tk;
    logic [7:0] h, m, s;
    int r;

    #12;
    chk("rst_hora",    hora_out,        8'h00);
    chk("rst_segundo", segundo_out,     8'h00);
    chk("rst_running", {7'd0, running}, 8'h00);
    chk("rst_done",    {7'd0, done},    8'h00);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Carry from seconds into minutes
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h58);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();

    // Reaching terminal count, then holding
    cyc(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h23, 8'h59, 8'h58);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    cyc(0, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00);

    // Rejected loads in IDLE
    cyc(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h24, 8'h00, 8'h00);
    idle();
    cyc(0, 1, 0, 0, 0, 8'h1A, 8'h00, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h23, 8'h59, 8'h59);
    idle();

    // Stop coincident with tick
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h09, 8'h59);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    tick();
    cyc(0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    tick();

    // Clear and load together while paused
    cyc(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(1, 1, 0, 0, 0, 8'h99, 8'h00, 8'h00);
    idle();

    // Asynchronous reset mid-run
    cyc(0, 1, 0, 0, 0, 8'h12, 8'h34, 8'h56);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    idle();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_hora",    hora_out,        8'h00);
    chk("arst_minuto",  minuto_out,      8'h00);
    chk("arst_segundo", segundo_out,     8'h00);
    chk("arst_running", {7'd0, running}, 8'h00);
    m_t = 0;
    m_mode = M_IDLE;
    @(negedge clk);
    reset = 1'b1;
    tick();
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r  = $urandom_range(0, 99);
      c  = (r < 2);
      l  = (r >= 2 && r < 7);
      sp = (r >= 7 && r < 10);
      st = (r >= 10 && r < 18);
      tk = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: begin
          h = to_bcd($urandom_range(0, 23));
          m = to_bcd($urandom_range(0, 59));
          s = to_bcd($urandom_range(0, 59));
        end
        1: begin
          h = 8'h23;
          m = 8'h59;
          s = to_bcd($urandom_range(40, 59));
        end
        default: begin
          h = 8'($urandom);
          m = 8'($urandom);
          s = 8'($urandom);
        end
      endcase
      cyc(c, l, sp, st, tk, h, m, s);
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
